multi_channel_ref_reader: RTL and testbench
===========================================

MULTI_CHANNEL_REF_READER -- requirements
Module: multi_channel_ref_reader

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of engine channels served, 2..32.
REQ-002 SHALL have parameter MAX_BURST, default 16: maximum blocks per DRAM burst, a power of two from 1 to 128.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ref_addr_in, input, NUM_CH*25 bits: per-channel start address in 256-bit block units; channel c occupies [25c+24:25c].
REQ-006 SHALL have port ref_length_in, input, NUM_CH*25 bits: per-channel reference length in bases.
REQ-007 SHALL have port ref_info_valid_in, input, NUM_CH bits: per-channel request valid.
REQ-008 SHALL have port ref_info_rdy_out, output, NUM_CH bits: per-channel request accepted.
REQ-009 SHALL have port ref_seq_block_out, output, 256 bits: reference block shared by all channels; base i sits at bits [2i+1:2i].
REQ-010 SHALL have port ref_seq_block_valid_out, output, NUM_CH bits: per-channel block valid.
REQ-011 SHALL have port ref_seq_block_rdy_in, input, NUM_CH bits: per-channel block accepted.
REQ-012 SHALL have ports rd_id_out (6 bits), rd_addr_out (32), rd_len_out (8), rd_info_valid_out (1) as outputs and rd_info_rdy_in (1) as input: the AXI read request channel.
REQ-013 SHALL have ports rd_data_in (256) and rd_data_valid_in (1) as inputs and rd_data_rdy_out (1) as output: the AXI read data channel; data returns in order.

Function
REQ-014 SHALL use a four-state FSM: IDLE, GRANT, ISSUE, DATA.
REQ-015 IDLE SHALL select a requesting channel round-robin, searching from rr_ptr upward with wrap at NUM_CH-1 to 0, then move to GRANT; with no requests it stays in IDLE.
REQ-016 GRANT SHALL drive ref_info_rdy_out[cur] high for exactly one cycle (one-hot, all other bits 0) and latch that channel's address and block count = ceil(length/128).
REQ-017 If the latched length is 0, GRANT SHALL return to IDLE with no burst issued and set rr_ptr to cur+1 mod NUM_CH; otherwise it SHALL move to ISSUE.
REQ-018 ISSUE SHALL drive rd_info_valid_out=1 with rd_addr_out = {addr,5'b0} zero-extended to 32 bits, rd_id_out = cur, rd_len_out = burst-1, where burst = min(remaining, MAX_BURST, 128 - addr[6:0]); this keeps every burst inside a 4 KB boundary.
REQ-019 Request fields SHALL stay stable while rd_info_valid_out=1 and rd_info_rdy_in=0; on the handshake the FSM SHALL move to DATA.
REQ-020 DATA SHALL combinationally drive ref_seq_block_out = rd_data_in, ref_seq_block_valid_out[cur] = rd_data_valid_in, and rd_data_rdy_out = ref_seq_block_rdy_in[cur]; all other valid bits SHALL be 0.
REQ-021 Each beat accepted in DATA SHALL increment addr and decrement remaining.
REQ-022 After the last beat of a burst, the FSM SHALL go to ISSUE if remaining > 0; otherwise it SHALL go to IDLE and set rr_ptr = cur+1 mod NUM_CH.
REQ-023 A request deasserted before its grant SHALL be ignored; requests from other channels that arrive mid-transfer SHALL wait and not be lost.
REQ-024 In any state other than DATA, rd_data_rdy_out SHALL be 0.
REQ-025 Address arithmetic SHALL be 25-bit unsigned and wrap from 2^25-1 to 0.

Reset
REQ-026 While rst=1 the block SHALL be in IDLE with rr_ptr=0 and cur, addr, remaining all 0.
REQ-027 While rst=1 every output SHALL be 0.
REQ-028 Asserting rst mid-burst SHALL abandon the transfer immediately; any DRAM beats still outstanding are the system reset's responsibility.

Configuration
REQ-029 With macro MCRR_TAIL_MASK_EN defined, on a channel's final block every base at index >= (length mod 128), when that value is nonzero, SHALL be forced to 2'b00 on ref_seq_block_out.
REQ-030 Without MCRR_TAIL_MASK_EN, ref_seq_block_out SHALL equal rd_data_in unmodified, and no length-remainder register SHALL be built.

Structure
REQ-031 Package mcrr_pkg SHALL hold the FSM state typedef, BLOCK_BASES=128, BLOCK_BYTES=32, and BOUNDARY_BLOCKS=128.
REQ-032 Sub-module rr_arbiter (NUM_CH parameter; inputs req and ptr; outputs a one-hot grant and its index) SHALL implement the round-robin search.

Verification
REQ-033 Channel 0 only, addr=0x10, len=300 -> one burst: rd_addr_out=0x200, rd_len_out=2; 3 beats to ch0; ref_info_rdy_out[0] pulses exactly once.
REQ-034 MAX_BURST=16, addr=0x7C, len=128*40 -> bursts of 4, 16, 16, 4 blocks at block addresses 0x7C, 0x80, 0x90, 0xA0.
REQ-035 All 4 channels request in the same cycle after reset -> grants in order 0,1,2,3; ch0 re-requesting after its transfer is served after ch3.
REQ-036 len=0 on ch2 -> rdy pulse, no rd_info_valid_out, back in IDLE within 2 cycles; ch3 is next in priority.
REQ-037 ref_seq_block_rdy_in[cur] held low for 5 cycles mid-burst -> rd_data_rdy_out=0, data held, no beat lost or duplicated.
REQ-038 rst pulsed while in DATA -> all outputs 0 in the same cycle; after release, a new ch1 request is served from rr_ptr=0.

Source files
------------

// File: rtl/mcrr_pkg.sv
// Shared types and constants for the multi-channel reference reader.
package mcrr_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, ISSUE, DATA} state_e;

  localparam int BLOCK_BASES     = 128;
  localparam int BLOCK_BYTES     = 32;
  localparam int BOUNDARY_BLOCKS = 128;
  localparam int AW              = 25;
  localparam int CNTW            = AW + 1 - 7;

  typedef struct packed {
    logic [5:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } rd_req_t;

  // Blocks in the next burst: capped by what is left, the burst limit and the 4 KB page edge.
  function automatic logic [7:0] burst_len(input logic [CNTW-1:0] rem,
                                           input logic [6:0] addr_lo,
                                           input int max_burst);
    logic [8:0] room;
    logic [8:0] lim;
    room = 9'(BOUNDARY_BLOCKS) - {2'b00, addr_lo};
    lim  = (room < 9'(max_burst)) ? room : 9'(max_burst);
    if (rem < CNTW'(lim)) lim = rem[8:0];
    return lim[7:0];
  endfunction

endpackage

// File: rtl/multi_channel_ref_reader_rr_arbiter.sv
// Round-robin request search starting at ptr, wrapping NUM_CH-1 -> 0.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     grant_idx
);

  logic [CW:0]   pos;
  logic [CW-1:0] idx;

  // Walk offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    pos       = '0;
    idx       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (CW+1)'(i);
      if (pos >= (CW+1)'(NUM_CH)) pos = pos - (CW+1)'(NUM_CH);
      idx = pos[CW-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/multi_channel_ref_reader.sv
// Serves reference-block fetches for NUM_CH engine channels over one AXI read port.
// Optional MCRR_TAIL_MASK_EN zeroes bases past the reference end on a channel's last block.
module multi_channel_ref_reader
  import mcrr_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*25-1:0] ref_addr_in,
  input  logic [NUM_CH*25-1:0] ref_length_in,
  input  logic [NUM_CH-1:0]    ref_info_valid_in,
  output logic [NUM_CH-1:0]    ref_info_rdy_out,
  output logic [255:0]         ref_seq_block_out,
  output logic [NUM_CH-1:0]    ref_seq_block_valid_out,
  input  logic [NUM_CH-1:0]    ref_seq_block_rdy_in,
  output logic [5:0]           rd_id_out,
  output logic [31:0]          rd_addr_out,
  output logic [7:0]           rd_len_out,
  output logic                 rd_info_valid_out,
  input  logic                 rd_info_rdy_in,
  input  logic [255:0]         rd_data_in,
  input  logic                 rd_data_valid_in,
  output logic                 rd_data_rdy_out
);

  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0][AW-1:0] addr_v;
  logic [NUM_CH-1:0][AW-1:0] len_v;
  assign addr_v = ref_addr_in;
  assign len_v  = ref_length_in;

  state_e          state_q, state_d;
  logic [CW-1:0]   cur_q, cur_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic [7:0]      beats_q, beats_d;
  logic [NUM_CH-1:0] info_rdy_q, info_rdy_d;
  logic            rd_valid_q, rd_valid_d;
  rd_req_t         rd_q, rd_d;

  logic [NUM_CH-1:0] arb_grant;
  logic [CW-1:0]     arb_idx;
  logic [CW-1:0]     next_ptr;
  logic [AW:0]       len_rnd;
  logic              in_data;
  logic              beat_acc;
  logic              issue;
  logic [255:0]      seq_blk;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (ref_info_valid_in),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign in_data  = (state_q == DATA);
  assign beat_acc = in_data && rd_data_valid_in && ref_seq_block_rdy_in[cur_q];
  assign next_ptr = (cur_q == CW'(NUM_CH - 1)) ? '0 : cur_q + CW'(1);
  assign len_rnd  = {1'b0, len_v[cur_q]} + (AW+1)'(BLOCK_BASES - 1);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rr_ptr_d   = rr_ptr_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    info_rdy_d = '0;
    rd_valid_d = rd_valid_q;
    rd_d       = rd_q;
    issue      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|ref_info_valid_in) begin
          cur_d      = arb_idx;
          info_rdy_d = arb_grant;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        addr_d = addr_v[cur_q];
        rem_d  = len_rnd[AW:7];
        if (rem_d == '0) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: begin
        if (rd_info_rdy_in) begin
          rd_valid_d = 1'b0;
          beats_d    = rd_q.len + 8'd1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (beat_acc) begin
          addr_d  = addr_q + AW'(1);
          rem_d   = rem_q - CNTW'(1);
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd1) begin
            if (rem_d != '0) begin
              state_d = ISSUE;
              issue   = 1'b1;
            end else begin
              state_d  = IDLE;
              rr_ptr_d = next_ptr;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Request fields are built from the post-update address so they are registered on ISSUE entry.
    if (issue) begin
      rd_valid_d = 1'b1;
      rd_d.id    = 6'(cur_q);
      rd_d.addr  = {2'b00, addr_d, 5'b00000};
      rd_d.len   = burst_len(rem_d, addr_d[6:0], MAX_BURST) - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      rr_ptr_q   <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      info_rdy_q <= '0;
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      info_rdy_q <= info_rdy_d;
      rd_valid_q <= rd_valid_d;
      rd_q       <= rd_d;
    end
  end

`ifdef MCRR_TAIL_MASK_EN
  logic [6:0] tail_q, tail_d;

  always_comb begin
    tail_d = tail_q;
    if (state_q == GRANT) tail_d = len_v[cur_q][6:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tail_q <= '0;
    else     tail_q <= tail_d;
  end

  always_comb begin
    seq_blk = rd_data_in;
    if (rem_q == CNTW'(1) && tail_q != '0) begin
      for (int i = 0; i < BLOCK_BASES; i++) begin
        if (7'(i) >= tail_q) seq_blk[2*i +: 2] = 2'b00;
      end
    end
  end
`else
  assign seq_blk = rd_data_in;
`endif

  // Data path is a combinational pass-through, only open while a burst is streaming.
  always_comb begin
    ref_seq_block_valid_out = '0;
    if (in_data) ref_seq_block_valid_out[cur_q] = rd_data_valid_in;
  end

  assign ref_seq_block_out = in_data ? seq_blk : '0;
  assign rd_data_rdy_out   = in_data && ref_seq_block_rdy_in[cur_q];
  assign ref_info_rdy_out  = info_rdy_q;
  assign rd_info_valid_out = rd_valid_q;
  assign rd_id_out         = rd_q.id;
  assign rd_addr_out       = rd_q.addr;
  assign rd_len_out        = rd_q.len;

endmodule

// File: tb/tb_multi_channel_ref_reader.sv
// Directed bench for multi_channel_ref_reader: DRAM responder plus grant/request/beat scoreboards.
module tb_multi_channel_ref_reader;

  localparam int NCH  = 4;
  localparam int MAXB = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*25-1:0]    ref_addr_in;
  logic [NCH*25-1:0]    ref_length_in;
  logic [NCH-1:0]       ref_info_valid_in;
  logic [NCH-1:0]       ref_info_rdy_out;
  logic [255:0]         ref_seq_block_out;
  logic [NCH-1:0]       ref_seq_block_valid_out;
  logic [NCH-1:0]       ref_seq_block_rdy_in;
  logic [5:0]           rd_id_out;
  logic [31:0]          rd_addr_out;
  logic [7:0]           rd_len_out;
  logic                 rd_info_valid_out;
  logic                 rd_info_rdy_in;
  logic [255:0]         rd_data_in;
  logic                 rd_data_valid_in;
  logic                 rd_data_rdy_out;

  multi_channel_ref_reader #(.NUM_CH(NCH), .MAX_BURST(MAXB)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .ref_addr_in             (ref_addr_in),
    .ref_length_in           (ref_length_in),
    .ref_info_valid_in       (ref_info_valid_in),
    .ref_info_rdy_out        (ref_info_rdy_out),
    .ref_seq_block_out       (ref_seq_block_out),
    .ref_seq_block_valid_out (ref_seq_block_valid_out),
    .ref_seq_block_rdy_in    (ref_seq_block_rdy_in),
    .rd_id_out               (rd_id_out),
    .rd_addr_out             (rd_addr_out),
    .rd_len_out              (rd_len_out),
    .rd_info_valid_out       (rd_info_valid_out),
    .rd_info_rdy_in          (rd_info_rdy_in),
    .rd_data_in              (rd_data_in),
    .rd_data_valid_in        (rd_data_valid_in),
    .rd_data_rdy_out         (rd_data_rdy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           ch;
    logic [255:0] d;
  } beat_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            exp_grant_q[$];
  logic [45:0]   exp_req_q[$];
  beat_t         exp_beat_q[$];
  logic [24:0]   pend[$];
  int            rdy_pulses[NCH];
  int            grant_cyc[NCH];
  int            beats_acc[NCH];
  logic [NCH-1:0] drop_pend;
  bit            hold_chk;
  logic [45:0]   hold_fields;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] blk_data(input logic [24:0] a);
    return {8{7'h35, a}};
  endfunction

  // Expected grant, bursts and beats for one channel transfer.
  task automatic push_xfer(input int ch, input logic [24:0] a, input int len, input bit auto_req);
    int left;
    int b;
    logic [24:0] p;
    beat_t e;
    left = (len + 127) / 128;
    p = a;
    exp_grant_q.push_back(ch);
    while (left > 0) begin
      b = 128 - int'(p[6:0]);
      if (b > MAXB) b = MAXB;
      if (b > left) b = left;
      if (auto_req) exp_req_q.push_back({6'(ch), 2'b00, p, 5'b00000, 8'(b - 1)});
      repeat (b) begin
        e.ch = ch;
        e.d  = blk_data(p);
`ifdef MCRR_TAIL_MASK_EN
        if (left == 1 && (len % 128) != 0)
          for (int i = len % 128; i < 128; i++) e.d[2*i +: 2] = 2'b00;
`endif
        exp_beat_q.push_back(e);
        p = p + 25'd1;
        left--;
      end
    end
  endtask

  task automatic set_req(input int ch, input logic [24:0] a, input int len);
    ref_addr_in[25*ch +: 25]   = a;
    ref_length_in[25*ch +: 25] = 25'(len);
    ref_info_valid_in[ch]      = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    while ((exp_grant_q.size() != 0 || exp_req_q.size() != 0 || exp_beat_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, (n < max), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_info_rdy"}, ref_info_rdy_out, '0);
    chk({tag, "_blk"}, ref_seq_block_out, '0);
    chk({tag, "_blk_valid"}, ref_seq_block_valid_out, '0);
    chk({tag, "_rd_req"}, {rd_id_out, rd_addr_out, rd_len_out}, '0);
    chk({tag, "_rd_valid"}, rd_info_valid_out, 1'b0);
    chk({tag, "_rd_rdy"}, rd_data_rdy_out, 1'b0);
  endtask

  // DRAM responder and output monitors; all sampling is on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rst) begin
      pend.delete();
      rd_info_rdy_in   = 1'b0;
      rd_data_valid_in = 1'b0;
      drop_pend        = '0;
      hold_chk         = 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) if (drop_pend[c]) ref_info_valid_in[c] = 1'b0;
      drop_pend = ref_info_rdy_out;
      if (ref_info_rdy_out != '0) begin
        chk("grant_onehot", $countones(ref_info_rdy_out), 1);
        for (int c = 0; c < NCH; c++) begin
          if (ref_info_rdy_out[c]) begin
            grant_cyc[c] = cyc;
            rdy_pulses[c]++;
            if (exp_grant_q.size() != 0) chk("grant_order", c, exp_grant_q.pop_front());
            else chk("grant_unexpected", c, 99);
          end
        end
      end
      if (hold_chk) begin
        chk("req_hold_valid", rd_info_valid_out, 1'b1);
        chk("req_hold_fields", {rd_id_out, rd_addr_out, rd_len_out}, hold_fields);
      end
      rd_info_rdy_in = ($urandom_range(0, 3) != 0);
      hold_chk       = rd_info_valid_out && !rd_info_rdy_in;
      hold_fields    = {rd_id_out, rd_addr_out, rd_len_out};
      if (rd_info_valid_out && rd_info_rdy_in) begin
        if (exp_req_q.size() != 0) chk("rd_req", {rd_id_out, rd_addr_out, rd_len_out}, exp_req_q.pop_front());
        else chk("rd_req_unexpected", rd_info_valid_out, 1'b0);
        for (int b = 0; b <= int'(rd_len_out); b++) pend.push_back(rd_addr_out[29:5] + 25'(b));
      end
      if (pend.size() != 0) begin
        rd_data_valid_in = ($urandom_range(0, 4) != 0);
        rd_data_in       = blk_data(pend[0]);
      end else begin
        rd_data_valid_in = 1'b0;
      end
      #1;
      if (rd_data_valid_in && rd_data_rdy_out) begin
        if (exp_beat_q.size() != 0) begin
          e = exp_beat_q.pop_front();
          chk("beat_valid", ref_seq_block_valid_out, 256'(1) << e.ch);
          chk("beat_data", ref_seq_block_out, e.d);
          beats_acc[e.ch]++;
        end else begin
          chk("beat_unexpected", rd_data_rdy_out, 1'b0);
        end
        void'(pend.pop_front());
      end
    end
  end

  initial begin
    int n;
    int k;
    rst                  = 1'b1;
    ref_addr_in          = '0;
    ref_length_in        = '0;
    ref_info_valid_in    = '0;
    ref_seq_block_rdy_in = '1;
    rd_info_rdy_in       = 1'b0;
    rd_data_valid_in     = 1'b0;
    rd_data_in           = {8{32'hDEADBEEF}};
    for (int c = 0; c < NCH; c++) begin
      rdy_pulses[c] = 0;
      grant_cyc[c]  = 0;
      beats_acc[c]  = 0;
    end
    drop_pend = '0;
    hold_chk  = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // All four request together; ch0 re-requests while others are served.
    push_xfer(0, 25'h1000, 256, 1'b1);
    push_xfer(1, 25'h2000, 384, 1'b1);
    push_xfer(2, 25'h3000, 128, 1'b1);
    push_xfer(3, 25'h4000, 200, 1'b1);
    push_xfer(0, 25'h5000, 128, 1'b1);
    @(negedge clk);
    set_req(0, 25'h1000, 256);
    set_req(1, 25'h2000, 384);
    set_req(2, 25'h3000, 128);
    set_req(3, 25'h4000, 200);
    n = 0;
    while (ref_info_valid_in[0] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ch0_grant_wait", (n < 200), 1'b1);
    @(negedge clk);
    set_req(0, 25'h5000, 128);
    wait_done("rr_all", 3000);

    // Single short transfer on ch0.
    k = rdy_pulses[0];
    push_xfer(0, 25'h10, 300, 1'b0);
    exp_req_q.push_back({6'd0, 32'h0000_0200, 8'd2});
    set_req(0, 25'h10, 300);
    wait_done("ch0_single", 2000);
    chk("ch0_rdy_pulses", rdy_pulses[0] - k, 1);

    // Burst split at the 4 KB boundary and by MAX_BURST.
    push_xfer(1, 25'h7C, 128 * 40, 1'b0);
    exp_req_q.push_back({6'd1, 32'h0000_0F80, 8'd3});
    exp_req_q.push_back({6'd1, 32'h0000_1000, 8'd15});
    exp_req_q.push_back({6'd1, 32'h0000_1200, 8'd15});
    exp_req_q.push_back({6'd1, 32'h0000_1400, 8'd3});
    set_req(1, 25'h7C, 128 * 40);
    wait_done("split", 3000);

    // Zero-length on ch2: pulse only, ch3 granted two cycles later.
    push_xfer(2, 25'h100, 0, 1'b1);
    push_xfer(3, 25'h200, 256, 1'b1);
    push_xfer(0, 25'h300, 128, 1'b1);
    set_req(2, 25'h100, 0);
    set_req(3, 25'h200, 256);
    set_req(0, 25'h300, 128);
    wait_done("len0", 2000);
    chk("len0_gap", grant_cyc[3] - grant_cyc[2], 2);

    // Downstream stall mid-burst on ch2.
    k = beats_acc[2];
    push_xfer(2, 25'h300, 768, 1'b1);
    set_req(2, 25'h300, 768);
    n = 0;
    while (beats_acc[2] < k + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("stall_wait", (n < 500), 1'b1);
    @(negedge clk);
    ref_seq_block_rdy_in[2] = 1'b0;
    repeat (5) begin
      #2;
      chk("stall_rdy", rd_data_rdy_out, 1'b0);
      @(negedge clk);
    end
    ref_seq_block_rdy_in[2] = 1'b1;
    wait_done("stall", 2000);

    // Reset mid-burst, then arbitration restarts from channel 0.
    push_xfer(1, 25'h400, 128, 1'b1);
    set_req(1, 25'h400, 128);
    wait_done("pre_rst", 1000);
    k = beats_acc[3];
    push_xfer(3, 25'h500, 128 * 20, 1'b1);
    set_req(3, 25'h500, 128 * 20);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(beats_acc[3] >= k + 2 && rd_data_rdy_out === 1'b1) && n < 500);
    chk("rst_wait_data", (n < 500), 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    exp_grant_q.delete();
    exp_req_q.delete();
    exp_beat_q.delete();
    ref_info_valid_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_xfer(1, 25'h700, 128, 1'b1);
    push_xfer(2, 25'h600, 128, 1'b1);
    @(negedge clk);
    set_req(1, 25'h700, 128);
    set_req(2, 25'h600, 128);
    wait_done("post_rst", 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
